// File: rtl/divmul_pkg.sv
// Shared definitions for the divide/multiply reconstruction datapath family.
// Holds default operand widths, the control FSM state encoding and the
// iteration-counter width helper.
package divmul_pkg;

   localparam int unsigned QW_DEF = 8;
   localparam int unsigned BW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width for BW iterations; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned bw);
      return (bw > 1) ? $clog2(bw) : 1;
   endfunction

endpackage

// File: rtl/divmul_step.sv
// One combinational shift-add step of the reconstruction multiplier.
// Ports:
//   acc, mcand   : current accumulator / shifted multiplicand (AW bits)
//   mplier       : remaining multiplier bits (BW bits), LSB consumed now
//   acc_nx       : acc + mcand when mplier[0] is set, else acc
//   mcand_nx     : mcand << 1
//   mplier_nx    : mplier >> 1
module divmul_step
   import divmul_pkg::*;
#(
   parameter int unsigned AW = QW_DEF + BW_DEF,
   parameter int unsigned BW = BW_DEF
) (
   input  logic [AW-1:0] acc,
   input  logic [AW-1:0] mcand,
   input  logic [BW-1:0] mplier,
   output logic [AW-1:0] acc_nx,
   output logic [AW-1:0] mcand_nx,
   output logic [BW-1:0] mplier_nx
);

   always_comb begin
      acc_nx    = acc;
      if (mplier[0]) begin
         acc_nx = acc + mcand;
      end
      mcand_nx  = mcand << 1;
      mplier_nx = mplier >> 1;
   end

endmodule

// File: rtl/divmul_recon_seq.sv
// Sequential reconstruction of a divider dividend: dividend = quot*divisor + rem,
// one divisor bit per cycle through a shift-add datapath.
// Optional feature macro: DIVMUL_RANGE_CHECK_EN (registers err = rem >= divisor).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (quot, divisor, rem)
//   out_valid / out_ready : result handshake (dividend, fits8, err)
//   dividend              : quot*divisor + rem, QW+BW bits
//   fits8                 : upper BW bits of dividend are zero
//   err                   : remainder-range flag, 0 when the check is not built
module divmul_recon_seq
   import divmul_pkg::*;
#(
   parameter int unsigned QW = QW_DEF,
   parameter int unsigned BW = BW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [QW-1:0]    quot,
   input  logic [BW-1:0]    divisor,
   input  logic [QW-1:0]    rem,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [QW+BW-1:0] dividend,
   output logic             fits8,
   output logic             err
);

   localparam int unsigned AW = QW + BW;
   localparam int unsigned CW = cnt_width(BW);

   state_t        state;
   state_t        state_nx;
   logic          load;
   logic          step_en;
   logic          finish;
   logic [AW-1:0] acc;
   logic [AW-1:0] mcand;
   logic [BW-1:0] mplier;
   logic [AW-1:0] acc_nx;
   logic [AW-1:0] mcand_nx;
   logic [BW-1:0] mplier_nx;
   logic [CW-1:0] cnt;

   divmul_step #(
      .AW (AW),
      .BW (BW)
   ) u_step (
      .acc       (acc),
      .mcand     (mcand),
      .mplier    (mplier),
      .acc_nx    (acc_nx),
      .mcand_nx  (mcand_nx),
      .mplier_nx (mplier_nx)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step_en  = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               load     = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            step_en = 1'b1;
            if (cnt == CW'(BW - 1)) begin
               finish   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Handshake flags track the state being entered, so they read as a state decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= (state_nx == IDLE);
         out_valid <= (state_nx == DONE);
      end
   end

   // Shift-add working registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (load) begin
         acc    <= AW'(rem);
         mcand  <= AW'(quot);
         mplier <= divisor;
         cnt    <= '0;
      end else if (step_en) begin
         acc    <= acc_nx;
         mcand  <= mcand_nx;
         mplier <= mplier_nx;
         cnt    <= cnt + CW'(1);
      end
   end

   // Result registers, updated only on the final step and held through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dividend <= '0;
         fits8    <= 1'b0;
      end else if (finish) begin
         dividend <= acc_nx;
         fits8    <= ~|acc_nx[AW-1:QW];
      end
   end

`ifdef DIVMUL_RANGE_CHECK_EN
   logic err_pend;

   // Range flag is judged on the captured operands and released with the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pend <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (load) begin
            err_pend <= (AW'(rem) >= AW'(divisor));
         end
         if (finish) begin
            err <= err_pend;
         end
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_divmul_recon_seq.sv
// Self-checking bench for divmul_recon_seq: vector table through a scoreboard
// queue, plus backpressure and mid-operation reset sequences.
module tb_divmul_recon_seq;

   localparam int unsigned QW = 8;
   localparam int unsigned BW = 4;
   localparam int unsigned AW = QW + BW;

`ifdef DIVMUL_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [QW-1:0] quot;
   logic [BW-1:0] divisor;
   logic [QW-1:0] rem;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] dividend;
   logic          fits8;
   logic          err;

   divmul_recon_seq #(.QW(QW), .BW(BW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .quot      (quot),
      .divisor   (divisor),
      .rem       (rem),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dividend  (dividend),
      .fits8     (fits8),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [QW-1:0] q;
      logic [BW-1:0] b;
      logic [QW-1:0] r;
      logic [AW-1:0] exp_d;
      logic          exp_f;
      logic          exp_e_rc;   // err value when the range check is built
   } vec_t;

   typedef struct {
      logic [AW-1:0] d;
      logic          f;
      logic          e;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
   endtask

   // Present one operand set (called at a negedge); returns one negedge after acceptance.
   task automatic send(input logic [QW-1:0] q, input logic [BW-1:0] b, input logic [QW-1:0] r,
                       input exp_t e);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      quot     = q;
      divisor  = b;
      rem      = r;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      quot     = QW'($urandom);
      divisor  = BW'($urandom);
      rem      = QW'($urandom);
   endtask

   // Wait for a result, check latency and values, then complete the handshake.
   task automatic collect(input string tag, input int exp_lat);
      int   lat = 0;
      exp_t e;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_dividend"}, 32'(dividend), 32'(e.d));
         chk({tag, "_fits8"},    32'(fits8),    32'(e.f));
         chk({tag, "_err"},      32'(err),      32'(e.e));
         chk({tag, "_model"},    32'(dividend), 32'(e.d));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_in_ready_after"},  32'(in_ready),  32'd1);
      chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
   endtask

   function automatic exp_t mk(input logic [QW-1:0] q, input logic [BW-1:0] b,
                               input logic [QW-1:0] r);
      exp_t e;
      e.d = AW'(q) * AW'(b) + AW'(r);
      e.f = (e.d[AW-1:QW] == '0);
      e.e = RC & (r >= QW'(b));
      return e;
   endfunction

   initial begin
      exp_t e;
      logic [AW-1:0] held;

      vecs[0] = '{q: 8'h10, b: 4'h3, r: 8'h02, exp_d: 12'h032, exp_f: 1'b1, exp_e_rc: 1'b0};
      vecs[1] = '{q: 8'hFF, b: 4'hF, r: 8'hFF, exp_d: 12'hFF0, exp_f: 1'b0, exp_e_rc: 1'b1};
      vecs[2] = '{q: 8'h55, b: 4'h0, r: 8'h09, exp_d: 12'h009, exp_f: 1'b1, exp_e_rc: 1'b1};
      vecs[3] = '{q: 8'd28,  b: 4'd7, r: 8'd4,  exp_d: 12'd200, exp_f: 1'b1, exp_e_rc: 1'b0};
      vecs[4] = '{q: 8'h00, b: 4'h5, r: 8'h03, exp_d: 12'h003, exp_f: 1'b1, exp_e_rc: 1'b0};
      vecs[5] = '{q: 8'hFF, b: 4'h1, r: 8'h00, exp_d: 12'h0FF, exp_f: 1'b1, exp_e_rc: 1'b0};
      vecs[6] = '{q: 8'h20, b: 4'h8, r: 8'h10, exp_d: 12'h110, exp_f: 1'b0, exp_e_rc: 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      quot      = '0;
      divisor   = '0;
      rem       = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_dividend",  32'(dividend),  32'd0);
      chk("rst_fits8",     32'(fits8),     32'd0);
      chk("rst_err",       32'(err),       32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table vectors; the independent model must agree with the hand values.
      for (int i = 0; i < 7; i++) begin
         e = mk(vecs[i].q, vecs[i].b, vecs[i].r);
         chk($sformatf("vec%0d_table_vs_model", i), 32'(e.d), 32'(vecs[i].exp_d));
         e.d = vecs[i].exp_d;
         e.f = vecs[i].exp_f;
         e.e = RC & vecs[i].exp_e_rc;
         send(vecs[i].q, vecs[i].b, vecs[i].r, e);
         chk($sformatf("vec%0d_busy_in_ready", i), 32'(in_ready), 32'd0);
         collect($sformatf("vec%0d", i), BW);
      end

      // Backpressure: result held for 3 cycles, new operands ignored.
      send(8'h12, 4'h5, 8'h03, mk(8'h12, 4'h5, 8'h03));
      begin
         int lat = 0;
         while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
         end
         chk("bp_latency", 32'(lat), 32'(BW));
      end
      held = dividend;
      chk("bp_value", 32'(held), 32'h05D);
      in_valid = 1'b1;
      quot     = 8'hAA;
      divisor  = 4'h2;
      rem      = 8'h01;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d_in_ready", k),  32'(in_ready),  32'd0);
         chk($sformatf("bp%0d_dividend", k),  32'(dividend),  32'(held));
      end
      in_valid = 1'b0;
      collect("bp", 0);
      repeat (BW + 2) @(negedge clk);
      chk("bp_no_phantom", 32'(out_valid), 32'd0);

      // Reset during the second BUSY cycle discards the operation.
      send(8'h33, 4'hA, 8'h01, mk(8'h33, 4'hA, 8'h01));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_dividend",  32'(dividend),  32'd0);
      chk("mrst_in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (BW + 2) @(negedge clk);
      chk("mrst_no_result", 32'(out_valid), 32'd0);
      send(8'h0B, 4'h9, 8'h02, mk(8'h0B, 4'h9, 8'h02));
      collect("post_rst", BW);
      chk("post_rst_model", 32'(mk(8'h0B, 4'h9, 8'h02).d), 32'h065);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/divmul_recon_seq.md
# divmul_recon_seq

Sequential reconstruction unit that inverts the 8-bit by 4-bit divider: it takes a quotient, a divisor and a remainder, and computes dividend = quotient × divisor + remainder with a shift-add datapath, one divisor bit per cycle. It sits downstream of the divider in the arithmetic self-check path and is also the multiply-accumulate primitive for the same datapath family. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake.

## Interface
- QW, default 8: quotient and remainder width.
- BW, default 4: divisor width. This is also the iteration count.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  unit can accept operands.
- quot  input  QW  quotient operand Q.
- divisor  input  BW  divisor operand B.
- rem  input  QW  remainder operand R.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- dividend  output  QW+BW  Q×B+R.
- fits8  output  1  high when dividend[QW+BW-1:QW] is zero, i.e. the result is a legal QW-bit dividend.
- err  output  1  remainder-range violation flag (see Configuration).

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE → BUSY on in_valid && in_ready. On that edge:
  - acc ← zero-extended R.
  - mcand ← zero-extended Q.
  - mplier ← B.
  - cnt ← 0.
  - Operands are captured; inputs may then change freely.
- Each BUSY cycle:
  - If mplier[0], acc ← acc + mcand.
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt+1.
- BUSY → DONE on the step where cnt == BW-1. On that edge dividend, fits8 and err are registered.
- DONE → IDLE on out_valid && out_ready. While in DONE, dividend, fits8 and err hold stable.
- Arithmetic is unsigned, and acc is QW+BW bits. Overflow cannot occur because (2^QW−1)(2^BW−1)+(2^QW−1) < 2^(QW+BW). No truncation logic is needed.
- B=0 is legal: the result is dividend=R.
- Q=0 is legal: the result is dividend=R.
- in_valid while not in IDLE is ignored; there is no queuing.
- Reset, asynchronous, at any time including mid-BUSY: state goes to IDLE and all registers go to 0. The in-flight operation is discarded and no result is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, dividend=0, fits8=0, err=0.
- Latency: operands accepted at edge N, then out_valid is high after edge N+BW. With the defaults that is edge N+4.
- Result handshake: out_valid && out_ready at edge M returns the FSM to IDLE. in_ready is high after edge M.
- Minimum initiation interval is BW+2 cycles, which is 6 with the defaults.
- out_valid does not depend combinationally on out_ready. in_ready is a pure state decode.

## Configuration
- Macro: DIVMUL_RANGE_CHECK_EN.
- Defined:
  - err ← (R >= B), evaluated on the captured operands and registered with dividend.
  - B=0 always gives err=1.
  - err is a flag only; the computation proceeds unchanged.
- Undefined: err is tied to 0 and the comparator is not synthesised.

## Structure
- Package divmul_pkg holds:
  - default QW/BW constants;
  - the state enum (IDLE, BUSY, DONE);
  - the counter width function $clog2(BW).
- Sub-module divmul_step: purely combinational single shift-add step. Inputs are acc, mcand and mplier; outputs are next acc, mcand and mplier. The top holds the FSM, counter, registers and handshakes.

## Test plan
- Q=0x10, B=3, R=2 → dividend=0x032 after 4 cycles, fits8=1, err=0.
- Q=0xFF, B=0xF, R=0xFF → dividend=0xFF0, fits8=0. err=1 with DIVMUL_RANGE_CHECK_EN, err=0 without.
- B=0, Q=0x55, R=0x09 → dividend=0x009, fits8=1. err=1 with the macro defined.
- Round trip from divider pair A=200, B=7 (Q=28, R=4) → dividend=200, fits8=1, err=0.
- Backpressure: hold out_ready low 3 cycles in DONE → outputs stable, in_ready=0, and a new in_valid is ignored. Releasing out_ready gives in_ready=1 one cycle later.
- Assert rst_n low during the 2nd BUSY cycle → immediately out_valid=0, dividend=0, in_ready=1. After release, a fresh operation completes correctly with nothing left over from the discarded one.
